// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state and even-parity helper.
package mmio_pkg;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 10;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } txState_e;

    function automatic logic evenParity(input logic [7:0] data);
        return ^data;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } txState_e;
`endif

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with first-word fall-through read; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, TX FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN for 8E1 frames (extra even-parity bit after DATA).
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLK_HZ     = 50000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] DIV_RELOAD = BW'(DIV - 1);

    txState_e      r_state;
    txState_e      w_nextState;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitCnt;
    logic [BW-1:0] r_baudCnt;
    logic          r_tx;
    logic          r_overflow;
    logic [31:0]   r_rdata;

    logic          w_isTxData;
    logic          w_isStatus;
    logic          w_push;
    logic          w_pop;
    logic          w_ovfClr;
    logic          w_baudDone;
    logic [7:0]    w_fifoData;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic          w_unused;

    assign sel        = (addr[31:3] == BASE_ADDR[31:3]);
    assign w_isTxData = sel && (addr[2:0] == TXDATA_OFS);
    assign w_isStatus = sel && (addr[2:0] == STATUS_OFS);
    assign w_push     = wr_en && w_isTxData;
    assign w_ovfClr   = wr_en && w_isStatus && wdata[ST_OVF];
    assign w_baudDone = (r_baudCnt == '0);
    assign w_unused   = ^wdata[31:8];
    assign tx         = r_tx;
    assign rdata      = r_rdata;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (wdata[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifoData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Every non-idle state lasts one baud period; STOP chains straight into the next START.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = S_START;
                end
            end
            S_START: begin
                if (w_baudDone) begin
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baudDone && (r_bitCnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_nextState = S_PARITY;
`else
                    w_nextState = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baudDone) begin
                    w_nextState = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baudDone) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = S_START;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_baudCnt <= '0;
        end else if (w_pop) begin
            r_shift   <= w_fifoData;
            r_bitCnt  <= '0;
            r_baudCnt <= DIV_RELOAD;
        end else if (r_state != S_IDLE) begin
            if (w_baudDone) begin
                r_baudCnt <= DIV_RELOAD;
                if (r_state == S_DATA) begin
                    r_bitCnt <= r_bitCnt + 3'd1;
                end
            end else begin
                r_baudCnt <= r_baudCnt - BW'(1);
            end
        end
    end

    // The line lags the state by one register so it never glitches on a transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                S_START:  r_tx <= 1'b0;
                S_DATA:   r_tx <= r_shift[r_bitCnt];
`ifdef UART_TX_PARITY_EN
                S_PARITY: r_tx <= evenParity(r_shift);
`endif
                default:  r_tx <= 1'b1;
            endcase
        end
    end

    // A new overflow on the same edge as a clear wins, so no dropped byte goes unreported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (w_ovfClr) begin
            r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_status                        = '0;
        w_status[ST_FULL]               = w_full;
        w_status[ST_EMPTY]              = w_empty;
        w_status[ST_BUSY]               = (r_state != S_IDLE);
        w_status[ST_OVF]                = r_overflow;
        w_status[ST_CNT_MSB:ST_CNT_LSB] = 7'(w_count);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (rd_en) begin
            r_rdata <= w_isStatus ? w_status : 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register accesses, serial frame scoreboard, reset abort.
// Honours UART_TX_PARITY_EN for 11-bit frames.
module tb_mmio_uart_tx;

    localparam int DIV = 50000000 / 115200;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;

    int nVec = 0;
    int nMis = 0;
    int cyc  = 0;
    logic [7:0] sb[$];
    int frameStarts[$];

    mmio_uart_tx dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .sel   (sel),
        .rdata (rdata),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one bus cycle and returns at the following negedge.
    task automatic applyStimulus(input logic isWrite, input logic [31:0] a, input logic [31:0] d,
                                 output logic selSeen);
        addr  = a;
        wdata = d;
        wr_en = isWrite;
        rd_en = !isWrite;
        #1 selSeen = sel;
        @(negedge clk);
        addr  = '0;
        wdata = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        logic s;
        applyStimulus(1'b1, a, d, s);
    endtask

    task automatic readReg(input logic [31:0] a, input logic [31:0] expData, input logic expSel,
                           input string tag);
        logic s;
        applyStimulus(1'b0, a, 32'd0, s);
        checkOutput({tag, "_sel"}, 32'(s), 32'(expSel));
        checkOutput(tag, rdata, expData);
    endtask

    // Single frame on an idle line: start edge timing and busy clearing one frame later.
    task automatic frameTiming(input logic [7:0] d, input string tag);
        writeReg(BASE, 32'(d));
        sb.push_back(d);
        readReg(BASE + 32'd4, 32'h010, 1'b1, {tag, "_status_push"});
        checkOutput({tag, "_tx_edge1"}, 32'(tx), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_tx_edge2"}, 32'(tx), 32'd0);
        repeat (FRAME - 2) @(negedge clk);
        readReg(BASE + 32'd4, 32'h006, 1'b1, {tag, "_status_busy_end"});
        readReg(BASE + 32'd4, 32'h002, 1'b1, {tag, "_status_idle_end"});
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 12 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drain_in_time"}, 32'(n < 12 * FRAME), 32'd1);
        repeat (FRAME + 2) @(negedge clk);
    endtask

    // Line monitor: decodes each frame and checks first and last sample of every bit period.
    initial begin : monitor
        logic [NBITS-1:0] bits;
        logic [7:0] d;
        logic ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                frameStarts.push_back(cyc);
                checkOutput("frame_expected", 32'(sb.size() != 0), 32'd1);
                d = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
                bits[0]   = 1'b0;
                bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
                bits[9]   = ^d;
`endif
                bits[NBITS-1] = 1'b1;
                ab = 1'b0;
                for (int k = 0; k < NBITS && !ab; k++) begin
                    for (int s = 0; s < DIV && !ab; s++) begin
                        if (k != 0 || s != 0) @(negedge clk);
                        if (rst !== 1'b1) ab = 1'b1;
                        else if (s == 0 || s == DIV - 1)
                            checkOutput($sformatf("frame_%02h_bit%0d", d, k), 32'(tx), 32'(bits[k]));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n0;
        addr  = '0;
        wdata = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_rdata", rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        readReg(BASE + 32'd4, 32'h002, 1'b1, "status_reset");
        readReg(BASE + 32'd8, 32'h000, 1'b0, "rd_out_of_window");
        readReg(BASE + 32'd4, 32'h002, 1'b1, "status_reset2");
        readReg(BASE + 32'd0, 32'h000, 1'b1, "rd_txdata");

        frameTiming(8'h55, "f55");

        // One byte goes straight to the shifter, eight fill the FIFO, the tenth is dropped.
        for (int i = 0; i < 10; i++) begin
            writeReg(BASE, 32'(i));
            if (i < 9) sb.push_back(8'(i));
        end
        readReg(BASE + 32'd4, 32'h08D, 1'b1, "status_overflow");
        writeReg(BASE + 32'd4, 32'h8);
        readReg(BASE + 32'd4, 32'h085, 1'b1, "status_ovf_cleared");
        waitDrain("burst");
        readReg(BASE + 32'd4, 32'h002, 1'b1, "status_burst_done");

        n0 = frameStarts.size();
        writeReg(BASE, 32'hA5);
        sb.push_back(8'hA5);
        writeReg(BASE, 32'h3C);
        sb.push_back(8'h3C);
        waitDrain("b2b");
        checkOutput("b2b_frame_count", 32'(frameStarts.size() - n0), 32'd2);
        if (frameStarts.size() >= n0 + 2)
            checkOutput("b2b_gap", 32'(frameStarts[n0+1] - frameStarts[n0]), 32'(FRAME));

        writeReg(BASE, 32'hFF);
        sb.push_back(8'hFF);
        repeat (2000) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_tx_high", 32'(tx), 32'd1);
        checkOutput("rst_rdata", rdata, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        readReg(BASE + 32'd4, 32'h002, 1'b1, "status_after_rst");
        n0 = frameStarts.size();
        repeat (FRAME + DIV) @(negedge clk);
        checkOutput("no_residual_frame", 32'(frameStarts.size() - n0), 32'd0);
        checkOutput("tx_idle_after_rst", 32'(tx), 32'd1);

`ifdef UART_TX_PARITY_EN
        frameTiming(8'h07, "f07");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data-memory path, downstream of the core's load/store port, beside `memory_integrated`. It decodes two word registers at `BASE_ADDR` and buffers bytes written by store instructions in a small FIFO. It serialises each byte as an 8N1 frame, or 8E1 when parity is enabled, at a fixed baud rate. It also exposes a status word that polling software reads back with loads.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; divisor `DIV = CLK_HZ / BAUD`, truncated (434 at defaults).
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..64.
- `BASE_ADDR`, 32'hFFFF_0000, word-aligned base of the register window.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address from the CPU data port.
- `wdata`  in  32  store data.
- `wr_en`  in  1  store strobe, one cycle per access.
- `rd_en`  in  1  load strobe, one cycle per access.
- `sel`  out  1  combinational; high when `addr[31:3] == BASE_ADDR[31:3]`.
- `rdata`  out  32  registered load data.
- `tx`  out  1  serial line, idle high.

## Operation
- Register map:
  - TXDATA at `BASE_ADDR+0`, write-only. A write with `sel` set pushes `wdata[7:0]`.
  - STATUS at `BASE_ADDR+4`, read/write. Read bits: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[10:4] FIFO count. All other bits read 0.
  - Writing STATUS with `wdata[3]=1` clears overflow. Other STATUS write bits are ignored.
- A push while the FIFO is full is dropped and sets overflow.
- A simultaneous pop and push on a full FIFO is accepted, and overflow stays unchanged.
- Reads of TXDATA, and reads with `sel` low, return 0.
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
  - IDLE with FIFO non-empty: pop into the shift register, load the bit counter with 0, go to START.
  - START, DATA, PARITY and STOP each hold for `DIV` cycles, timed by a down-counter reloaded with `DIV-1`.
  - DATA sends bits LSB first; the bit counter wraps 7→0, then the FSM leaves DATA.
  - STOP goes to START directly when the FIFO is non-empty (back-to-back frames), otherwise to IDLE.
- `tx` is registered: 0 in START, the data bit in DATA, 1 in STOP and IDLE.
- Reset values: `tx`=1, `rdata`=0, FSM IDLE, FIFO empty, count 0, overflow 0, baud counter 0.
- Reset asserted mid-frame forces `tx` high immediately and discards the FIFO contents and the partial frame.

## Timing
- A push on edge N is visible in STATUS from edge N+1.
- A pop occurs on edge N+1 when the FSM is IDLE, and `tx` falls on edge N+2.
- A frame lasts `10*DIV` cycles, or `11*DIV` with parity.
- Back-to-back frames have no idle gap.
- Load latency is 1: `rdata` is valid on the edge after the `rd_en` cycle, and it holds until the next load.
- STATUS reflects state as of the edge on which `rd_en` is sampled.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state follows DATA and sends the even-parity bit, the XOR of the 8 data bits, for `DIV` cycles. The frame is 11 bits.
- Macro undefined: no PARITY state and no parity logic. The frame is 10 bits.

## Structure
- Shared package `mmio_pkg`:
  - register offsets `TXDATA_OFS`=0 and `STATUS_OFS`=4;
  - STATUS bit-position constants;
  - the FSM state enum.
- Sub-module `tx_fifo`: synchronous FIFO with push, pop, full, empty and count outputs, depth parameterised.
- The FSM, baud counter and address decode stay in `mmio_uart_tx`.

## Test plan
- Write 0x55 to TXDATA, idle line:
  - `tx` is low on edge 2.
  - `tx` then shows 0,1,0,1,0,1,0,1,0,1, each held 434 cycles.
  - busy reads 0 after 4340 cycles.
- Ten consecutive TXDATA writes, 0x00..0x09:
  - 0x00 is in flight and 0x01..0x08 are buffered.
  - The 0x09 write is dropped.
  - STATUS reads 0x08D: count 8, overflow, full.
  - Writing STATUS with 0x8 clears overflow.
- Two writes, 0xA5 then 0x3C: the frames are contiguous, with the STOP bit of frame 1 directly followed by the START bit of frame 2.
- STATUS read in reset state returns 0x002; a read at `BASE_ADDR+8` returns 0 with `sel`=0.
- Assert `rst` 2000 cycles into a 0xFF frame:
  - `tx`=1 immediately.
  - After release, STATUS reads 0x002 and no residual frame is sent.
- With `UART_TX_PARITY_EN`, write 0x07: the bit after DATA is 1 and the frame lasts 4774 cycles.
